// File: rtl/net_link_pkg.sv
// ---------------------------------------------------------------------------
// net_link_pkg
// Shared definitions for the serial link transmitter and receiver: the frame
// state enumeration, the default bit period, the line idle level and the
// frame-length constant.
//
// Build option: NET_TX_PARITY_EN adds an even-parity bit to every frame,
// which lengthens the frame by one bit period.
// ---------------------------------------------------------------------------
package net_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } link_state_e;

  // 50 MHz system clock / 115200 baud
  localparam int CLKS_PER_BIT_DEF = 434;

  localparam logic LINE_IDLE = 1'b1;

  // Bit periods per frame on top of the payload: start + stop (+ parity).
`ifdef NET_TX_PARITY_EN
  localparam int FRAME_OVERHEAD_BITS = 3;
`else
  localparam int FRAME_OVERHEAD_BITS = 2;
`endif

  // Cycles from the accept edge to the DONE entry edge.
  function automatic int frame_cycles(input int data_w, input int clks_per_bit);
    return (data_w + FRAME_OVERHEAD_BITS) * clks_per_bit;
  endfunction

  localparam int FRAME_CYCLES_DEF = frame_cycles(32, CLKS_PER_BIT_DEF);

endpackage

// File: rtl/net_baud_tick.sv
// ---------------------------------------------------------------------------
// net_baud_tick
// Bit-period timer. A down-counter reloaded on clr (or reset) and on its own
// terminal count, giving a one-cycle tick every CLKS_PER_BIT cycles. After a
// clear the first tick comes exactly CLKS_PER_BIT cycles later.
//
// Ports
//   clk    in   system clock
//   reset  in   synchronous, active-high
//   clr    in   restart the bit period (held high while idle)
//   tick   out  high on the last cycle of each bit period
// ---------------------------------------------------------------------------
module net_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // tick is not gated by clr: the FSM derives clr from the transition that
  // tick itself causes, so gating would form a combinational loop.
  assign tick = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (clr || tick) cnt_d = LOAD;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= LOAD;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/net_tx_link.sv
// ---------------------------------------------------------------------------
// net_tx_link
// Serial transmitter driven by the snd instruction. A held tx_signal is
// accepted in IDLE, the word is latched and sent as start bit, DATA_W data
// bits LSB first, optional even parity, stop bit. rdy stalls the processor
// until the one-cycle DONE state, which lets the PC advance.
//
// Build option: NET_TX_PARITY_EN inserts the PARITY state between DATA and
// STOP; without it no parity logic is built.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-high
//   tx_signal  in   send request (level, held while snd is current)
//   tx_data    in   word to send, sampled on the accept cycle only
//   rdy        out  stall request, combinational
//   tx_line    out  serial line, registered, idles high
//   tx_done    out  one-cycle pulse in DONE
//
// state  | meaning
// IDLE   | line high; accept tx_signal and latch tx_data
// START  | start bit (0)
// DATA   | DATA_W data bits, LSB first
// PARITY | even parity over the latched word (parity build only)
// STOP   | stop bit (1)
// DONE   | one cycle, tx_done high, rdy low, tx_signal ignored
// ---------------------------------------------------------------------------
module net_tx_link
  import net_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_signal,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rdy,
  output logic              tx_line,
  output logic              tx_done
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  link_state_e       state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic              tx_line_q, tx_line_d;
  logic              tx_done_q, tx_done_d;
`ifdef NET_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic tick;
  logic baud_clr;

  net_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .clr   (baud_clr),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
`ifdef NET_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tx_signal) begin
          shreg_d   = tx_data;
          bit_idx_d = '0;
`ifdef NET_TX_PARITY_EN
          parity_d  = ^tx_data;
`endif
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (bit_idx_q == LAST_IDX) begin
            bit_idx_d = '0;
`ifdef NET_TX_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
`ifdef NET_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (tick) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Line level follows the state being entered so it is registered yet
    // aligned with the state register.
    case (state_d)
      ST_START: tx_line_d = 1'b0;
      ST_DATA:  tx_line_d = shreg_d[0];
`ifdef NET_TX_PARITY_EN
      ST_PARITY: tx_line_d = parity_d;
`endif
      default:  tx_line_d = LINE_IDLE;
    endcase

    tx_done_d = (state_d == ST_DONE);

    // Restart the bit period on every state entry; hold it cleared in IDLE.
    baud_clr = (state_d != state_q) || (state_q == ST_IDLE);
  end

  always_comb begin
    rdy = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: rdy = tx_signal;
        ST_DONE: rdy = 1'b0;
        default: rdy = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      tx_line_q <= LINE_IDLE;
      tx_done_q <= 1'b0;
`ifdef NET_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      tx_line_q <= tx_line_d;
      tx_done_q <= tx_done_d;
`ifdef NET_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx_line = tx_line_q;
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_net_tx_link.sv
// ---------------------------------------------------------------------------
// tb_net_tx_link
// Directed bench for net_tx_link with CLKS_PER_BIT=4, DATA_W=32. Inputs are
// driven just after negedge, outputs sampled on negedge.
// ---------------------------------------------------------------------------
module tb_net_tx_link;

  localparam int CPB    = 4;
  localparam int DATA_W = 32;
`ifdef NET_TX_PARITY_EN
  localparam int SLOTS  = DATA_W + 3;
`else
  localparam int SLOTS  = DATA_W + 2;
`endif
  localparam int FRAME  = SLOTS * CPB;   // 136, or 140 with parity

  logic              clk;
  logic              reset;
  logic              tx_signal;
  logic [DATA_W-1:0] tx_data;
  logic              rdy;
  logic              tx_line;
  logic              tx_done;

  int total;
  int bad;

  net_tx_link #(
    .CLKS_PER_BIT (CPB),
    .DATA_W       (DATA_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_signal (tx_signal),
    .tx_data   (tx_data),
    .rdy       (rdy),
    .tx_line   (tx_line),
    .tx_done   (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        par;      // hand-computed even parity
    bit          corrupt;  // overwrite tx_data one cycle after accept
    bit          b2b;      // keep tx_signal high into the next frame
  } frame_vec_t;

  frame_vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic exp_bit(input logic [31:0] w, input logic par, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= DATA_W) return w[slot-1];
`ifdef NET_TX_PARITY_EN
    if (slot == DATA_W + 1) return par;
`endif
    return 1'b1;
  endfunction

  // Called during an IDLE cycle (after negedge). Returns at the DONE negedge.
  task automatic frame(input logic [31:0] w, input logic par, input bit corrupt);
    tx_signal = 1'b1;
    tx_data   = w;
    #1;
    chk("accept_rdy", rdy, 1);
    chk("accept_line", tx_line, 1);
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (corrupt && k == 0) tx_data = 32'hFFFF_FFFF;
      chk($sformatf("line_slot%0d", k / CPB), tx_line, exp_bit(w, par, k / CPB));
      chk("busy_rdy", rdy, 1);
      chk("busy_done", tx_done, 0);
    end
    @(negedge clk);
    chk("done_pulse", tx_done, 1);
    chk("done_rdy", rdy, 0);
    chk("done_line", tx_line, 1);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    vecs[0] = '{data: 32'hA5A5_0F01, par: 1'b1, corrupt: 1'b0, b2b: 1'b0};
    vecs[1] = '{data: 32'h0000_0007, par: 1'b1, corrupt: 1'b0, b2b: 1'b0};
    vecs[2] = '{data: 32'h0000_0003, par: 1'b0, corrupt: 1'b0, b2b: 1'b0};
    vecs[3] = '{data: 32'h8000_0001, par: 1'b0, corrupt: 1'b0, b2b: 1'b1};
    vecs[4] = '{data: 32'h7FFF_FFFE, par: 1'b0, corrupt: 1'b0, b2b: 1'b0};
    vecs[5] = '{data: 32'h1234_5678, par: 1'b1, corrupt: 1'b1, b2b: 1'b0};

    // Reset for 3 cycles with a pending request: rdy must stay low.
    reset     = 1'b1;
    tx_signal = 1'b1;
    tx_data   = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_rdy", rdy, 0);
      chk("rst_line", tx_line, 1);
      chk("rst_done", tx_done, 0);
    end
    tx_signal = 1'b0;
    reset     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_rdy", rdy, 0);
      chk("idle_line", tx_line, 1);
      chk("idle_done", tx_done, 0);
    end

    for (int v = 0; v < 6; v++) begin
      frame(vecs[v].data, vecs[v].par, vecs[v].corrupt);
      if (vecs[v].b2b) begin
        // Next frame call sees the IDLE cycle right after DONE with rdy high.
        @(negedge clk);
      end else begin
        tx_signal = 1'b0;
        @(negedge clk);
        chk("post_rdy", rdy, 0);
        chk("post_line", tx_line, 1);
        chk("post_done", tx_done, 0);
      end
    end

    // Reset at cycle 50 of a frame aborts it.
    tx_signal = 1'b1;
    tx_data   = 32'hA5A5_0F01;
    #1;
    chk("abort_accept_rdy", rdy, 1);
    for (int k = 0; k < 50; k++) @(negedge clk);
    chk("abort_pre_line", tx_line, exp_bit(32'hA5A5_0F01, 1'b1, 49 / CPB));
    reset = 1'b1;
    @(negedge clk);
    chk("abort_line", tx_line, 1);
    chk("abort_done", tx_done, 0);
    chk("abort_rdy", rdy, 0);
    reset     = 1'b0;
    tx_signal = 1'b0;
    for (int k = 0; k < FRAME + 10; k++) begin
      @(negedge clk);
      chk("abort_quiet_line", tx_line, 1);
      chk("abort_quiet_done", tx_done, 0);
      chk("abort_quiet_rdy", rdy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
